// File: rtl/barrett_const_gen.sv
// Barrett constant generator: mu = floor(2^(2N)/M) and 2^(2N) mod M by
// restoring division, one quotient bit per clock.
module barrett_const_gen #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   M_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*N-1:0] const_out,
    output logic [N-1:0]   rem_out
);

    localparam int CW = $clog2(2*N+1);
    localparam logic [CW-1:0] CNT_TOP = CW'(2*N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   m_q, m_d;
    logic [N:0]     r_q, r_d;
    logic [2*N:0]   q_q, q_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [2*N-1:0] const_q, const_d;
    logic [N-1:0]   rem_q, rem_d;

    logic           d_bit;
    logic           take;
    logic [N:0]     m_ext;
    logic [N:0]     r_shift;
    logic [N:0]     r_next;
    logic [2*N:0]   q_next;

    always_comb begin
        // The dividend 2^(2N) contributes its single 1 on the first iteration only.
        d_bit   = (cnt_q == CNT_TOP);
        m_ext   = {1'b0, m_q};
        r_shift = (r_q << 1) | {{N{1'b0}}, d_bit};
        take    = (r_shift >= m_ext);
        r_next  = take ? (r_shift - m_ext) : r_shift;
        q_next  = (q_q << 1) | {{2*N{1'b0}}, take};

        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        r_d     = r_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        const_d = const_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d = M_in;
                    r_d = '0;
                    q_d = '0;
                    if (M_in[N-1:1] == '0) begin
                        // Moduli 0 and 1 have no meaningful constant: saturate and flag.
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        const_d = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_TOP;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CALC: begin
                r_d = r_next;
                q_d = q_next;
                if (cnt_q == '0) begin
                    // Quotient bit 2N is always 0 for M >= 2 and is dropped.
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    const_d = q_next[2*N-1:0];
                    rem_d   = r_next[N-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            const_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            r_q     <= r_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            const_q <= const_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign const_out = const_q;
    assign rem_out   = rem_q;

endmodule

// File: tb/tb_barrett_const_gen.sv
// Bench for barrett_const_gen at N=8: table vectors, random moduli against an
// arithmetic model, and hand sequences for ignored start and mid-run reset.
module tb_barrett_const_gen;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   M_in = '0;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*N-1:0] const_out;
    logic [N-1:0]   rem_out;

    int ncmp = 0;
    int nerr = 0;

    barrett_const_gen #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .M_in      (M_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .const_out (const_out),
        .rem_out   (rem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   m;
        logic [2*N-1:0] c;
        logic [N-1:0]   r;
        logic           e;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model_const(input logic [N-1:0] m);
        longint unsigned num;
        num = longint'(1) << (2*N);
        if (m < 2) return '1;
        return (2*N)'(num / longint'(m));
    endfunction

    function automatic logic [N-1:0] model_rem(input logic [N-1:0] m);
        longint unsigned num;
        num = longint'(1) << (2*N);
        if (m < 2) return '0;
        return N'(num % longint'(m));
    endfunction

    // Issue one start and follow it to the done pulse, checking latency and busy.
    task automatic run_op(input logic [N-1:0] m, input logic [2*N-1:0] ec,
                          input logic [N-1:0] er, input logic ee, input string tag);
        int k;
        int lat;
        logic busy_bad;
        lat = (m < 2) ? 0 : 2*N + 1;
        busy_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        M_in  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            if (busy !== (m >= 2)) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " busy"}, 64'(busy_bad), 64'(0));
        chk({tag, " const"}, 64'(const_out), 64'(ec));
        chk({tag, " rem"}, 64'(rem_out), 64'(er));
        chk({tag, " err"}, 64'(err), 64'(ee));
        chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int k;
        int ndone;
        logic [N-1:0] rm;

        tbl[0] = '{m: 8'hFB, c: 16'h0105, r: 8'h19, e: 1'b0};
        tbl[1] = '{m: 8'h80, c: 16'h0200, r: 8'h00, e: 1'b0};
        tbl[2] = '{m: 8'hFF, c: 16'h0101, r: 8'h01, e: 1'b0};
        tbl[3] = '{m: 8'h03, c: 16'h5555, r: 8'h01, e: 1'b0};
        tbl[4] = '{m: 8'h01, c: 16'hFFFF, r: 8'h00, e: 1'b1};
        tbl[5] = '{m: 8'h00, c: 16'hFFFF, r: 8'h00, e: 1'b1};
        tbl[6] = '{m: 8'h02, c: 16'h8000, r: 8'h00, e: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset err", 64'(err), 64'(0));
        chk("reset const", 64'(const_out), 64'(0));
        chk("reset rem", 64'(rem_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].m, tbl[i].c, tbl[i].r, tbl[i].e, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            rm = N'($urandom_range(0, (1 << N) - 1));
            run_op(rm, model_const(rm), model_rem(rm), rm < 2, $sformatf("rnd%0d_m%0h", i, rm));
        end

        // A second start arriving mid-computation must be ignored.
        @(negedge clk);
        start = 1'b1;
        M_in  = 8'hFB;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (k = 0; k < 30; k++) begin
            if (k == 4) begin
                start = 1'b1;
                M_in  = 8'h03;
            end
            if (k == 5) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ignore done_count", 64'(ndone), 64'(1));
        chk("ignore const", 64'(const_out), 64'h0105);
        chk("ignore rem", 64'(rem_out), 64'h19);

        // Reset in the middle of a computation.
        @(negedge clk);
        start = 1'b1;
        M_in  = 8'hFB;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst const", 64'(const_out), 64'(0));
        chk("rst rem", 64'(rem_out), 64'(0));
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("rst no_done", 64'(ndone), 64'(0));
        run_op(8'hFF, 16'h0101, 8'h01, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
